// File: rtl/dm_pkg.sv
// Shared types and constants for the dm_pipe data-memory block.
// Holds access-size encodings, FSM states, latency limits and the request bundle.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        err;
    } req_t;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic: byte enables, store merge and load select/extend.
// Ports: i_size/i_off/i_unsigned/i_wdata/i_old in; o_be/o_merged/o_rdata out.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old,
    output logic [3:0]  o_be,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [31:0] w_rep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store data is replicated across lanes so the enable alone picks the lane.
    always_comb begin
        o_be  = 4'b0000;
        w_rep = i_wdata;
        case (i_size)
            SZ_B: begin
                o_be  = 4'b0001 << i_off;
                w_rep = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_be  = i_off[1] ? 4'b1100 : 4'b0011;
                w_rep = {2{i_wdata[15:0]}};
            end
            SZ_W: begin
                o_be  = 4'b1111;
                w_rep = i_wdata;
            end
            default: begin
                o_be  = 4'b0000;
                w_rep = i_wdata;
            end
        endcase
    end

    always_comb begin
        o_merged = i_old;
        for (int k = 0; k < 4; k++) begin
            o_merged[8*k +: 8] = o_be[k] ? w_rep[8*k +: 8] : i_old[8*k +: 8];
        end
    end

    assign w_byte = i_old[{i_off, 3'b000} +: 8];
    assign w_half = i_old[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_rdata = '0;
        case (i_size)
            SZ_B: o_rdata = i_unsigned ? {24'b0, w_byte}
                                       : {{24{w_byte[7]}}, w_byte};
            SZ_H: o_rdata = i_unsigned ? {16'b0, w_half}
                                       : {{16{w_half[15]}}, w_half};
            SZ_W: o_rdata = i_old;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/dm_pipe.sv
// Fixed-latency data memory with load/store, alignment checks and a store log.
// Ports: clk/reset; req_* handshake in; resp_valid/resp_rdata/resp_err/busy out.
module dm_pipe
    import dm_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t      r_state;
    state_t      w_state_n;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_n;
    req_t        r_req;
    req_t        w_in;
    req_t        w_cur;
    logic [31:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_commit;
    logic              w_wr;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_old;
    logic [3:0]        w_be;
    logic [31:0]       w_merged;
    logic [31:0]       w_rdata;

    assign w_err = (req_size == 2'b11)
                 | ((req_size == SZ_H) & req_addr[0])
                 | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                 | ((req_addr >> (ADDR_W + 2)) != 32'd0);

    assign w_in = '{
        we:    req_we,
        size:  req_size,
        uns:   req_unsigned,
        addr:  req_addr,
        wdata: req_wdata,
        pc:    req_pc,
        err:   w_err
    };

    // With LAT=1 the commit edge is the accept edge, so the live inputs
    // must feed the lane logic while still in IDLE.
    assign w_cur = (r_state == ST_IDLE) ? w_in : r_req;

    assign w_idx = w_cur.addr[ADDR_W+1:2];
    assign w_old = r_mem[w_idx];

    dm_lane u_lane (
        .i_size     (w_cur.size),
        .i_off      (w_cur.addr[1:0]),
        .i_unsigned (w_cur.uns),
        .i_wdata    (w_cur.wdata),
        .i_old      (w_old),
        .o_be       (w_be),
        .o_merged   (w_merged),
        .o_rdata    (w_rdata)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = req_valid & req_ready;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_commit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LAT <= LAT_MIN) begin
                        w_state_n = ST_RESP;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_n = ST_WAIT;
                        w_cnt_n   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_n = ST_RESP;
                    w_cnt_n   = 4'd0;
                    w_commit  = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign w_wr = w_commit & w_cur.we & ~w_cur.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_req   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_accept) begin
                r_req <= w_in;
            end
            if (w_wr) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid & r_req.err;
    assign resp_rdata = (resp_valid & ~r_req.we & ~r_req.err) ? w_rdata : 32'd0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && w_wr) begin
            $display("@%h: *%h <= %h", w_cur.pc,
                     {w_cur.addr[31:2], 2'b00}, w_merged);
        end
    end
`endif

endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 Parameter ADDR_W, default 12, word-index width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter LAT, default 2, legal range 1..8, cycles from request accept to response.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 req_pc  input  32  PC of the issuing instruction, used for the store log only.
REQ-013 resp_valid  output  1  one-cycle response strobe.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  request was rejected (misaligned, out of range, or illegal size).
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, RESP. req_ready = 1 only in IDLE.
REQ-018 Accept: req_valid & req_ready at edge T latches we/size/unsigned/addr/wdata/pc, loads latency counter with LAT-1, and moves to WAIT (or directly to RESP when LAT=1).
REQ-019 WAIT decrements the counter each cycle and moves to RESP when the counter reaches 0; resp_valid is high in exactly the cycle T+LAT.
REQ-020 RESP always returns to IDLE on the next edge, so back-to-back requests are accepted at most once every LAT+1 cycles.
REQ-021 Error: size 11; half with addr[0]=1; word with addr[1:0]!=00; or any of addr[31:ADDR_W+2] nonzero. The request gets resp_err=1, resp_rdata=0, and no memory write.
REQ-022 Load data is taken from the word at addr[ADDR_W+1:2] and selected by addr[1:0] for byte or addr[1] for half.
REQ-023 Load extension follows req_unsigned for byte and half; req_unsigned is ignored for word.
REQ-024 Store merge: only the addressed byte lanes are replaced; all other lanes keep their old contents.
REQ-025 A store commits on the edge that enters RESP, so a load accepted afterwards observes it.
REQ-026 On each committed store, simulation prints "@<pc hex>: *<word-aligned addr hex> <= <merged word hex>"; nothing is printed for errored stores.
REQ-027 Inputs that arrive while req_ready=0 are ignored and have no side effects.
REQ-028 resp_rdata and resp_err are held at 0 outside RESP.

Reset
REQ-029 reset returns the FSM to IDLE and clears the counter and captured request; resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=1 from the following cycle.
REQ-030 Reset during WAIT or RESP drops the pending request: no write commits, no response is issued, and no log line is printed.
REQ-031 reset clears every memory word to 0; the initial contents are also all 0.

Structure
REQ-032 Shared package dm_pkg holds the size encodings (SZ_B, SZ_H, SZ_W), the FSM state enum, and the LAT range limits.
REQ-033 One combinational sub-module, dm_lane, performs byte-enable generation, store merge, and load select/extend.

Verification (ADDR_W=12, LAT=2 unless noted)
REQ-034 Store word 0x12345678 @0x10, then lb @0x13 -> resp_rdata 0x00000012; lh @0x12 -> 0x00001234; resp_valid exactly 2 cycles after each accept.
REQ-035 sb 0x80 @0x21, then lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080; lw @0x20 -> 0x00008000.
REQ-036 sw @0x22 -> resp_err=1; lw @0x4000 -> resp_err=1 with no write; lw @0x20 afterwards -> unchanged 0x00008000.
REQ-037 Assert reset one cycle after accepting sw 0xDEADBEEF @0x0 -> no resp_valid, no log line; lw @0x0 afterwards -> 0.
REQ-038 Hold req_valid high continuously with LAT=1 and LAT=8 -> accepts spaced by 2 and 9 cycles respectively; busy high between each accept and its response.
